shift_rotate_seq: RTL and testbench
===================================

// Module: shift_rotate_seq
// PURPOSE
//  Parametrised sequential shift/rotate unit; successor to the fixed-amount combinational SHR.
//  Runtime amount and op (SHR/ROTR/SHL; SAR optional) with valid/ready on both sides.
//  Shifts STEP bits per clock, trading latency for area in the SHA-256 message-schedule and compression datapaths.
// PARAMETERS
//  WIDTH  32  data width in bits; power of two, >=8
//  STEP   4   max bits shifted per clock; power of two, 1..WIDTH
//  AMT_W  $clog2(WIDTH)  width of shift amount (derived localparam, not overridable)
// PORTS
//  clk        in   1      single clock; all logic on rising edge
//  rst        in   1      reset, asynchronous and active-high
//  in_valid   in   1      request valid
//  in_ready   out  1      unit idle, can accept request
//  in_data    in   WIDTH  operand
//  in_amt     in   AMT_W  shift amount, 0..WIDTH-1
//  in_op      in   2      00 SHR, 01 ROTR, 10 SHL, 11 SAR (see CONFIGURATION)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_data   out  WIDTH  result
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE, in_ready=1, out_valid=0, out_data=0, internal rem/op regs=0.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: in_ready=1. Accept on in_valid&&in_ready edge: latch data, op, rem=in_amt.
//   Accept with in_amt==0 goes directly to DONE; in_amt>0 goes to SHIFT.
//  SHIFT: in_ready=0. Each edge shifts by s=min(rem,STEP), rem-=s, per op:
//   SHR zero-fill from MSB; SHL zero-fill from LSB; ROTR wraps LSBs into MSBs; SAR fills with sign bit.
//   Goes to DONE on the edge where rem<=STEP.
//  Latency: out_valid high after exactly ceil(in_amt/STEP) edges following the accept edge.
//   amt=0: out_valid high in the cycle right after accept; result equals in_data.
//  DONE: out_valid=1, out_data stable and held while out_ready=0 (no limit).
//   Edge with out_ready=1 -> IDLE; out_valid drops and in_ready rises the next cycle.
//   No accept in the same cycle as output handoff: max one request every ceil(amt/STEP)+2 cycles.
//  in_valid while busy is ignored (no accept); in_data/in_amt/in_op are don't-care when not accepted.
//  out_data updates only on accept/shift edges; holds its last value in IDLE.
//  Amount arithmetic: rem is AMT_W bits, unsigned, never underflows; s is an explicit min.
//  rst asserted mid-SHIFT or mid-DONE: immediate return to reset values; in-flight result discarded, no out_valid.
// CONFIGURATION
//  Macro SHIFTER_SAR_EN.
//   Defined: op 11 = arithmetic shift right (sign fill from data MSB captured at accept).
//   Undefined: op 11 decodes exactly as SHR (zero fill); no sign-fill logic synthesised.
// STRUCTURE
//  Shared package/include sha_shift_pkg: op codes OP_SHR/OP_ROTR/OP_SHL/OP_SAR, state codes
//   ST_IDLE/ST_SHIFT/ST_DONE, amount-width function.
//  One sub-module shift_step: combinational single-step shifter (data, op, s<=STEP -> data'),
//   instanced once; the FSM and rem counter live in shift_rotate_seq.
// TESTING (WIDTH=32, STEP=4 unless stated)
//  SHR 0x80000000 amt 4, out_ready=1 -> 0x08000000, out_valid 1 edge after accept.
//  ROTR 0x00000001 amt 7 -> 0x02000000 after 2 edges; SHL 0x000000FF amt 31 -> 0x80000000 after 8 edges.
//  op 11 on 0x80000000 amt 4 -> 0xF8000000 with SHIFTER_SAR_EN, 0x08000000 without.
//  amt 0 on 0xDEADBEEF each op -> 0xDEADBEEF, out_valid next cycle; in_valid held high while busy -> exactly one accept.
//  out_ready low 5 cycles in DONE -> out_valid=1, out_data stable, in_ready=0 throughout; IDLE after release.
//  rst pulse mid-SHIFT (ROTR amt 31, 3rd edge) -> in_ready=1, out_valid=0, out_data=0 at once; next request correct.

Source files
------------

// File: rtl/sha_shift_pkg.sv
// Shared op codes, FSM state codes and amount-width helper for the sequential shifter.
package sha_shift_pkg;
  localparam logic [1:0] OP_SHR  = 2'b00;
  localparam logic [1:0] OP_ROTR = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_SAR  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int amt_width(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/shift_rotate_seq_if.sv
// Request/response valid-ready bundle for shift_rotate_seq.
interface shift_rotate_seq_if #(
  parameter int WIDTH = 32
);
  localparam int AMT_W = sha_shift_pkg::amt_width(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by s (0..STEP) bits per op.
// Op 11 is an arithmetic shift only when SHIFTER_SAR_EN is defined, else plain SHR.
module shift_step
  import sha_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic [SW-1:0]    s,
  output logic [WIDTH-1:0] result
);
  always_comb begin
    result = data >> s;
    case (op)
      // shifting left by WIDTH yields zero, so s==0 degenerates cleanly
      OP_ROTR: result = (data >> s) | (data << (WIDTH - int'(s)));
      OP_SHL:  result = data << s;
`ifdef SHIFTER_SAR_EN
      OP_SAR:  result = $unsigned($signed(data) >>> s);
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/shift_rotate_seq.sv
// Sequential shift/rotate unit: STEP bits per clock, valid/ready on both sides.
// Optional SAR on op 11 via SHIFTER_SAR_EN.
module shift_rotate_seq
  import sha_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input logic             clk,
  input logic             rst,
  shift_rotate_seq_if.slave bus
);
  localparam int AMT_W = amt_width(WIDTH);
  localparam int SW    = $clog2(STEP + 1);

  logic [1:0]       state;
  logic [AMT_W-1:0] rem;
  logic [1:0]       op;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] stepped;
  logic [SW-1:0]    s;

  // explicit min keeps rem from ever wrapping below zero
  assign s = (int'(rem) < STEP) ? SW'(rem) : SW'(STEP);

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .data   (data),
    .op     (op),
    .s      (s),
    .result (stepped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      rem   <= '0;
      op    <= '0;
      data  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.in_valid) begin
          data  <= bus.in_data;
          op    <= bus.in_op;
          rem   <= bus.in_amt;
          state <= (bus.in_amt == '0) ? ST_DONE : ST_SHIFT;
        end
        ST_SHIFT: begin
          data <= stepped;
          rem  <= rem - AMT_W'(s);
          if (int'(rem) <= STEP) state <= ST_DONE;
        end
        ST_DONE: if (bus.out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.out_data  = data;
endmodule

// File: tb/tb_shift_rotate_seq.sv
// Self-checking bench for shift_rotate_seq (WIDTH=32, STEP=4); honours SHIFTER_SAR_EN.
module tb_shift_rotate_seq;
  localparam int WIDTH = 32;
  localparam int STEP  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_rotate_seq_if #(.WIDTH(WIDTH)) bus ();
  shift_rotate_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference result straight from the op definitions, whole amount at once.
  function automatic logic [31:0] ref_op(input logic [31:0] d, input logic [1:0] op, input int amt);
    logic [63:0] w;
    case (op)
      2'b00: return d >> amt;
      2'b01: begin w = {d, d} >> amt; return w[31:0]; end
      2'b10: return d << amt;
      default: begin
`ifdef SHIFTER_SAR_EN
        return $unsigned($signed(d) >>> amt);
`else
        return d >> amt;
`endif
      end
    endcase
  endfunction

  // Transaction-level model: busy for ceil(amt/STEP) edges, then holds result until taken.
  logic        m_busy, m_valid;
  int          m_left, m_accepts;
  logic [31:0] m_data;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_left <= 0; m_data <= '0;
    end else if (m_valid) begin
      if (bus.out_ready) m_valid <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin m_busy <= 1'b0; m_valid <= 1'b1; end
    end else if (bus.in_valid) begin
      m_accepts <= m_accepts + 1;
      m_data    <= ref_op(bus.in_data, bus.in_op, int'(bus.in_amt));
      m_left    <= (int'(bus.in_amt) + STEP - 1) / STEP;
      if (bus.in_amt == '0) m_valid <= 1'b1;
      else                  m_busy  <= 1'b1;
    end
  end

  initial begin
    m_accepts = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("cmp_in_ready", {31'b0, bus.in_ready}, {31'b0, !m_busy && !m_valid});
        chk("cmp_out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
        if (!m_busy) chk("cmp_out_data", bus.out_data, m_data);
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.in_ready) chk({nm, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic req(input logic [31:0] d, input logic [1:0] op, input logic [4:0] amt,
                     input logic [31:0] exp, input int edges, input string nm);
    int n = 0;
    wait_idle(nm);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_op = op; bus.in_amt = amt;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    while (!bus.out_valid && n < 64) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, n, edges);
    chk({nm, "_data"}, bus.out_data, exp);
  endtask

  initial begin
    int hi, acc0;
    logic [31:0] held;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0; bus.in_op = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    @(negedge clk); #2 rst = 1'b0;

    req(32'h8000_0000, 2'b00, 5'd4,  32'h0800_0000, 1, "shr4");
    req(32'h0000_0001, 2'b01, 5'd7,  32'h0200_0000, 2, "rotr7");
    req(32'h0000_00FF, 2'b10, 5'd31, 32'h8000_0000, 8, "shl31");
`ifdef SHIFTER_SAR_EN
    req(32'h8000_0000, 2'b11, 5'd4,  32'hF800_0000, 1, "op3_4");
    req(32'h8000_0000, 2'b11, 5'd31, 32'hFFFF_FFFF, 8, "op3_31");
`else
    req(32'h8000_0000, 2'b11, 5'd4,  32'h0800_0000, 1, "op3_4");
    req(32'h8000_0000, 2'b11, 5'd31, 32'h0000_0001, 8, "op3_31");
`endif
    req(32'hFFFF_FFFF, 2'b00, 5'd5,  32'h07FF_FFFF, 2, "shr5");
    req(32'h1234_5678, 2'b10, 5'd8,  32'h3456_7800, 2, "shl8");
    req(32'h1234_5678, 2'b01, 5'd16, 32'h5678_1234, 4, "rotr16");
    for (int o = 0; o < 4; o++)
      req(32'hDEAD_BEEF, 2'(o), 5'd0, 32'hDEAD_BEEF, 0, $sformatf("amt0_op%0d", o));

    // in_valid held through the whole transaction: one accept, one result beat
    wait_idle("hold");
    acc0 = m_accepts; hi = 0;
    bus.in_valid = 1'b1; bus.in_data = 32'h1; bus.in_op = 2'b10; bus.in_amt = 5'd8;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin hi++; chk("hold_data", bus.out_data, 32'h0000_0100); end
      if (i == 0) bus.in_data = 32'h0000_FFFF;
      if (i == 3) bus.in_valid = 1'b0;
    end
    chk("hold_valid_beats", hi, 1);
    chk("hold_accepts", m_accepts - acc0, 1);

    // backpressure in DONE
    bus.out_ready = 1'b0;
    req(32'h0000_00F0, 2'b00, 5'd4, 32'h0000_000F, 1, "bp");
    held = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_stable", bus.out_data, held);
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("bp_rel_out_valid", {31'b0, bus.out_valid}, 32'd0);

    // async reset mid-shift
    wait_idle("mid_rst");
    bus.in_valid = 1'b1; bus.in_data = 32'h9234_5678; bus.in_op = 2'b01; bus.in_amt = 5'd31;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midrst_out_data", bus.out_data, 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    req(32'h9234_5678, 2'b01, 5'd31, 32'h2468_ACF1, 8, "post_rst");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
